// File: rtl/hex_dbg_pkg.sv
// Shared constants and FSM state type for the hex overlay debug scheduler.
// Sizes: 16-slot shadow store of 8-bit bytes, shown as two 8-byte pages.
package hex_dbg_pkg;

   localparam int unsigned N_SLOTS    = 16;
   localparam int unsigned SLOT_W     = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned PAGE_BYTES = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCopy  = 2'd1,
      StLatch = 2'd2
   } sched_state_e;

endpackage

// File: rtl/mod_rr_arbiter.sv
// Round-robin arbiter. Grants the first asserted request at or after the
// rotating pointer (wrapping); the pointer then moves just past the winner.
// Ports:
//   in_clk, in_rst_n  clock, async active-low reset
//   in_req            per-requester request
//   out_grant         one-hot grant (combinational, this cycle)
//   out_grant_idx     index of the granted requester
//   out_valid         a grant is being issued this cycle
module mod_rr_arbiter #(
   parameter int unsigned N     = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [N-1:0]     in_req,
   output logic [N-1:0]     out_grant,
   output logic [IDX_W-1:0] out_grant_idx,
   output logic             out_valid
);

   logic [IDX_W-1:0] r_ptr;
   int unsigned      w_cand;

   always_comb begin
      out_grant     = '0;
      out_grant_idx = '0;
      out_valid     = 1'b0;
      w_cand        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = (32'(r_ptr) + k) % N;
         if (!out_valid && in_req[w_cand]) begin
            out_valid         = 1'b1;
            out_grant_idx     = IDX_W'(w_cand);
            out_grant[w_cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_ptr <= '0;
      end else if (out_valid) begin
         r_ptr <= (out_grant_idx == IDX_W'(N - 1)) ? '0 : out_grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mod_hex_debug_sched.sv
// Debug byte scheduler for the hex overlay. Requesters write bytes into a
// 16-byte shadow store through a round-robin arbiter; once per frame one
// 8-byte page is copied to stable outputs and a latch pulse is issued.
// Ports:
//   in_pix_clk, in_rst_n        pixel clock, async active-low reset
//   in_pix_x, in_pix_y          raster position (frame event source)
//   in_req/_slot/_data, out_ack requester write interface
//   in_freeze                   hold display, skip copies
//   out_latch, out_data0..7     overlay latch pulse and page bytes
//   out_page                    page most recently copied
module mod_hex_debug_sched
   import hex_dbg_pkg::*;
#(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned LATCH_LINE   = 500,
   parameter int unsigned LATCH_CYCLES = 4,
   parameter int unsigned PAGE_FRAMES  = 60
) (
   input  logic                      in_pix_clk,
   input  logic                      in_rst_n,
   input  logic [9:0]                in_pix_x,
   input  logic [9:0]                in_pix_y,
   input  logic [N_REQ-1:0]          in_req,
   input  logic [SLOT_W*N_REQ-1:0]   in_req_slot,
   input  logic [DATA_W*N_REQ-1:0]   in_req_data,
   output logic [N_REQ-1:0]          out_ack,
   input  logic                      in_freeze,
   output logic                      out_latch,
   output logic [DATA_W-1:0]         out_data0,
   output logic [DATA_W-1:0]         out_data1,
   output logic [DATA_W-1:0]         out_data2,
   output logic [DATA_W-1:0]         out_data3,
   output logic [DATA_W-1:0]         out_data4,
   output logic [DATA_W-1:0]         out_data5,
   output logic [DATA_W-1:0]         out_data6,
   output logic [DATA_W-1:0]         out_data7,
   output logic                      out_page
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (PAGE_FRAMES == 0) ? 1 : $clog2(PAGE_FRAMES + 1);
   localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PAGE_FRAMES == 0) ? 0 : PAGE_FRAMES - 1);

   logic [N_REQ-1:0]  w_gnt;
   logic [IDX_W-1:0]  w_gnt_idx;
   logic              w_gnt_valid;
   logic [SLOT_W-1:0] w_slot;
   logic [DATA_W-1:0] w_wdata;

   logic [DATA_W-1:0] r_shadow [N_SLOTS];
   logic [DATA_W-1:0] r_out    [PAGE_BYTES];
   logic [N_REQ-1:0]  r_ack;

   logic              w_hit;
   logic              r_hit;
   logic              r_evt;

   sched_state_e      r_state;
   sched_state_e      w_state_next;
   logic              w_do_copy;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic              r_page_sel;  // page the next copy will read
   logic              r_page_out;  // page the last copy read

   mod_rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .in_clk        (in_pix_clk),
      .in_rst_n      (in_rst_n),
      .in_req        (in_req),
      .out_grant     (w_gnt),
      .out_grant_idx (w_gnt_idx),
      .out_valid     (w_gnt_valid)
   );

   assign w_slot  = in_req_slot[w_gnt_idx * SLOT_W +: SLOT_W];
   assign w_wdata = in_req_data[w_gnt_idx * DATA_W +: DATA_W];

   always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_ack <= '0;
         for (int i = 0; i < N_SLOTS; i++) r_shadow[i] <= '0;
      end else begin
         r_ack <= w_gnt;
         if (w_gnt_valid) r_shadow[w_slot] <= w_wdata;
      end
   end

   assign w_hit = (in_pix_x == 10'd0) && (in_pix_y == 10'(LATCH_LINE));

   // Rising edge only, so a held raster position fires once per frame.
   always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_hit <= 1'b0;
         r_evt <= 1'b0;
      end else begin
         r_hit <= w_hit;
         r_evt <= w_hit & ~r_hit;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_do_copy    = 1'b0;
      unique case (r_state)
         StIdle:  if (r_evt && !in_freeze) w_state_next = StCopy;
         StCopy: begin
            w_do_copy    = 1'b1;
            w_state_next = StLatch;
         end
         StLatch: if (r_lat_cnt == LAT_W'(LATCH_CYCLES - 1)) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state     <= StIdle;
         r_lat_cnt   <= '0;
         r_frame_cnt <= '0;
         r_page_sel  <= 1'b0;
         r_page_out  <= 1'b0;
         for (int i = 0; i < PAGE_BYTES; i++) r_out[i] <= '0;
      end else begin
         r_state   <= w_state_next;
         r_lat_cnt <= (r_state == StLatch) ? r_lat_cnt + 1'b1 : '0;
         if (w_do_copy) begin
            // Non-blocking reads: a same-cycle shadow write shows next frame.
            for (int i = 0; i < PAGE_BYTES; i++) r_out[i] <= r_shadow[{r_page_sel, 3'(i)}];
            r_page_out <= r_page_sel;
            if (PAGE_FRAMES != 0 && r_frame_cnt == CNT_LAST) begin
               r_frame_cnt <= '0;
               r_page_sel  <= ~r_page_sel;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   assign out_ack   = r_ack;
   assign out_latch = (r_state == StLatch);
   assign out_page  = r_page_out;
   assign out_data0 = r_out[0];
   assign out_data1 = r_out[1];
   assign out_data2 = r_out[2];
   assign out_data3 = r_out[3];
   assign out_data4 = r_out[4];
   assign out_data5 = r_out[5];
   assign out_data6 = r_out[6];
   assign out_data7 = r_out[7];

endmodule

// File: tb/tb_mod_hex_debug_sched.sv
// Directed bench: two instances share all inputs, one with a fixed page
// (PAGE_FRAMES=0) and one paging every 2 frames.
module tb_mod_hex_debug_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  pix_x = 10'd5;
   logic [9:0]  pix_y = 10'd0;
   logic [3:0]  req = '0;
   logic [15:0] req_slot = '0;
   logic [31:0] req_data = '0;
   logic        freeze = 1'b0;

   logic [3:0]  ack0, ack2;
   logic        latch0, latch2;
   logic        page0, page2;
   logic [7:0]  d0 [8];
   logic [7:0]  d2 [8];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mod_hex_debug_sched #(
      .N_REQ(4), .LATCH_LINE(500), .LATCH_CYCLES(4), .PAGE_FRAMES(0)
   ) dut0 (
      .in_pix_clk(clk), .in_rst_n(rst_n), .in_pix_x(pix_x), .in_pix_y(pix_y),
      .in_req(req), .in_req_slot(req_slot), .in_req_data(req_data), .out_ack(ack0),
      .in_freeze(freeze), .out_latch(latch0),
      .out_data0(d0[0]), .out_data1(d0[1]), .out_data2(d0[2]), .out_data3(d0[3]),
      .out_data4(d0[4]), .out_data5(d0[5]), .out_data6(d0[6]), .out_data7(d0[7]),
      .out_page(page0)
   );

   mod_hex_debug_sched #(
      .N_REQ(4), .LATCH_LINE(500), .LATCH_CYCLES(4), .PAGE_FRAMES(2)
   ) dut2 (
      .in_pix_clk(clk), .in_rst_n(rst_n), .in_pix_x(pix_x), .in_pix_y(pix_y),
      .in_req(req), .in_req_slot(req_slot), .in_req_data(req_data), .out_ack(ack2),
      .in_freeze(freeze), .out_latch(latch2),
      .out_data0(d2[0]), .out_data1(d2[1]), .out_data2(d2[2]), .out_data3(d2[3]),
      .out_data4(d2[4]), .out_data5(d2[5]), .out_data6(d2[6]), .out_data7(d2[7]),
      .out_page(page2)
   );

   function automatic logic [63:0] pack(input logic [7:0] b [8]);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = b[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise the latch line for one cycle, then watch 10 cycles (sample k
   // taken 1 ns after edge k). A pulse must cover samples 2..5 exactly and
   // the data must not move while it is observed.
   task automatic frame(input string tag, input bit exp_pulse);
      logic [9:0]  obs0, obs2, exp_v;
      logic [63:0] s0, s2;
      logic        chg0, chg2;
      exp_v = exp_pulse ? 10'b00_0011_1100 : 10'b0;
      chg0 = 1'b0;
      chg2 = 1'b0;
      s0 = '0;
      s2 = '0;
      pix_x = 10'd0;
      pix_y = 10'd500;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) pix_x = 10'd1;
         obs0[k] = latch0;
         obs2[k] = latch2;
         if (k == 2) begin
            s0 = pack(d0);
            s2 = pack(d2);
         end else if (k > 2) begin
            if (pack(d0) !== s0) chg0 = 1'b1;
            if (pack(d2) !== s2) chg2 = 1'b1;
         end
      end
      chk({tag, "_latch0"}, obs0, exp_v);
      chk({tag, "_latch2"}, obs2, exp_v);
      chk({tag, "_stable"}, {chg0, chg2}, 2'b00);
   endtask

   task automatic wr(input int idx, input logic [3:0] slot, input logic [7:0] data);
      bit got;
      got = 1'b0;
      req_slot[idx*4 +: 4] = slot;
      req_data[idx*8 +: 8] = data;
      req[idx] = 1'b1;
      for (int c = 0; c < 8 && !got; c++) begin
         @(posedge clk);
         #1;
         if (ack0[idx]) got = 1'b1;
      end
      req[idx] = 1'b0;
      chk("wr_ack", got, 1'b1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] exp_d2 [5];
      logic       exp_p2 [5];
      bit         spurious;
      exp_d2 = '{8'h11, 8'h11, 8'h88, 8'h88, 8'h11};
      exp_p2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_latch", {latch0, latch2}, 2'b00);
      chk("rst_ack", {ack0, ack2}, 8'h00);
      chk("rst_page", {page0, page2}, 2'b00);
      chk("rst_data", pack(d0) | pack(d2), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // First frame: empty store
      frame("f1", 1'b1);
      chk("f1_d0", pack(d0), 64'h0);
      chk("f1_d2", pack(d2), 64'h0);
      chk("f1_page", {page0, page2}, 2'b00);

      // All requesters held: strict rotation from pointer 0
      req_slot = {4'd15, 4'd14, 4'd13, 4'd12};
      req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (k == 7) req = 4'b0000;
         chk($sformatf("rr%0d_ack0", k), ack0, 4'b0001 << (k % 4));
         chk($sformatf("rr%0d_ack2", k), ack2, 4'b0001 << (k % 4));
      end
      @(posedge clk);
      #1;
      chk("rr_idle_ack", ack0, 4'b0000);

      // Same slot from two requesters: later grant wins
      req_slot = {4'd0, 4'd0, 4'd3, 4'd3};
      req_data = {8'h00, 8'h00, 8'h5A, 8'hA5};
      req = 4'b0011;
      @(posedge clk);
      #1;
      chk("ss_ack_first", ack0, 4'b0001);
      req[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("ss_ack_second", ack0, 4'b0010);
      req[1] = 1'b0;
      @(posedge clk);
      #1;
      chk("ss_ack_done", ack0, 4'b0000);

      frame("f2", 1'b1);
      chk("f2_d0_3", d0[3], 8'h5A);
      chk("f2_d2_3", d2[3], 8'h5A);
      chk("f2_page2", page2, 1'b0);
      frame("f3", 1'b1);
      chk("f3_d2_4", d2[4], 8'hC0);
      chk("f3_page2", page2, 1'b1);
      chk("f3_d0_4", d0[4], 8'h00);
      chk("f3_page0", page0, 1'b0);

      // Fresh reset, then paging every two frames
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wr(0, 4'd0, 8'h11);
      wr(0, 4'd8, 8'h88);
      for (int f = 0; f < 5; f++) begin
         frame($sformatf("pg%0d", f), 1'b1);
         chk($sformatf("pg%0d_d2", f), d2[0], exp_d2[f]);
         chk($sformatf("pg%0d_page2", f), page2, exp_p2[f]);
         chk($sformatf("pg%0d_d0", f), {page0, d0[0]}, 9'h011);
      end

      // Freeze: events ignored, counter holds, writes still land
      freeze = 1'b1;
      wr(0, 4'd0, 8'h22);
      for (int f = 0; f < 3; f++) begin
         frame($sformatf("frz%0d", f), 1'b0);
         chk($sformatf("frz%0d_d0", f), d0[0], 8'h11);
         chk($sformatf("frz%0d_d2", f), d2[0], 8'h11);
      end
      freeze = 1'b0;
      frame("thaw1", 1'b1);
      chk("thaw1_d0", d0[0], 8'h22);
      chk("thaw1_d2", {page2, d2[0]}, 9'h022);
      frame("thaw2", 1'b1);
      chk("thaw2_d2", {page2, d2[0]}, 9'h188);

      // Reset in the second latch cycle
      pix_x = 10'd0;
      pix_y = 10'd500;
      @(posedge clk);
      #1 pix_x = 10'd1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mid_latch_on", {latch0, latch2}, 2'b11);
      @(posedge clk);
      #1;
      chk("mid_d2_before", d2[0], 8'h88);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_latch_off", {latch0, latch2}, 2'b00);
      chk("mid_data_clr", {d0[0], d2[0]}, 16'h0000);
      chk("mid_page_clr", page2, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      spurious = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (latch0 || latch2) spurious = 1'b1;
      end
      chk("post_rst_quiet", spurious, 1'b0);
      frame("post", 1'b1);
      chk("post_data", pack(d0) | pack(d2), 64'h0);
      chk("post_page", {page0, page2}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_hex_debug_sched.md
Name: mod_hex_debug_sched

Overview:
Collects debug bytes from several requesters into a 16-byte shadow store via a round-robin req/ack arbiter. Once per frame, at a fixed scanline, it copies one 8-byte page to stable output registers and pulses the latch that drives the hex overlay's in_latch/in_data0..7. Pages alternate every PAGE_FRAMES frames so 16 bytes share the 8-byte overlay. It sits between CPU/PPU debug taps and the hex overlay, in the pixel clock domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
LATCH_LINE, 500, in_pix_y value at which the frame event fires (must lie outside the overlay rows 8..15)
LATCH_CYCLES, 4, width of out_latch pulse in clocks (>=1)
PAGE_FRAMES, 60, frames per page before toggling; 0 = page fixed at 0

Ports:
in_pix_clk  input  1  pixel clock; all logic on its rising edge
in_rst_n  input  1  asynchronous active-low reset
in_pix_x  input  10  current pixel x
in_pix_y  input  10  current pixel y
in_req  input  N_REQ  per-requester write request
in_req_slot  input  4*N_REQ  slot index 0..15 per requester; requester i uses bits [4i+3:4i]
in_req_data  input  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i]
out_ack  output  N_REQ  one-cycle acknowledge per requester
in_freeze  input  1  1 = suppress page copies and latching; display holds
out_latch  output  1  latch pulse to the overlay
out_data0..out_data7  output  8 each  page bytes 0..7, stable while out_latch is high
out_page  output  1  page currently shown (slots 0-7 = 0, slots 8-15 = 1)

Behaviour:
- Reset (async, in_rst_n=0): shadow store = 0, out_data* = 0, out_latch = 0, out_ack = 0, out_page = 0, frame counter = 0, RR pointer = 0, FSM = IDLE. Reset asserted mid-pulse drops out_latch immediately.
- Arbiter: each cycle, grant the first asserted in_req at or after the RR pointer (wrapping). Write the granted data into shadow[slot] that cycle. Register out_ack[grant] high the next cycle for exactly 1 cycle. Pointer = grant+1 mod N_REQ. No request means no write and the pointer holds.
- Requester rule: hold req/slot/data stable until ack. A req still high on the ack cycle is a new request. Throughput: one write/cycle total. Worst-case wait: N_REQ cycles.
- Two requesters on the same slot: the later grant wins.
- Frame event: registered rising edge of (in_pix_x==0 && in_pix_y==LATCH_LINE). At most one event per frame.
- FSM IDLE -> COPY on frame event with in_freeze=0. With in_freeze=1, the event is ignored and the frame counter holds.
- COPY (1 cycle):
  - out_data0..7 <= shadow[{page,0..7}] using pre-write values. A write in the same cycle appears next frame.
  - Frame counter update: if PAGE_FRAMES!=0 and counter==PAGE_FRAMES-1, counter <= 0 and page toggles. Otherwise counter+1.
  - Page toggle takes effect for the next copy. out_page always matches the page just copied.
  - Go to LATCH.
- LATCH: out_latch=1 for LATCH_CYCLES cycles, then IDLE. Frame events in COPY/LATCH are dropped. out_data* never change while out_latch=1.
- Latency: event detected at cycle T; COPY at T+1; out_data valid and out_latch rising at T+2; out_latch falls at T+2+LATCH_CYCLES.
- Arbiter writes continue in all FSM states.
- Counter width: $clog2(PAGE_FRAMES+1), minimum 1 bit.

Decomposition:
- Package hex_dbg_pkg:
  - N_SLOTS=16, SLOT_W=4, DATA_W=8, PAGE_BYTES=8
  - FSM state enum {IDLE, COPY, LATCH}
- Sub-module mod_rr_arbiter: parameter N; inputs clk, rst_n, req; outputs one-hot grant and grant index. Pointer register lives inside it.

Test Plan:
- Reset, then frame event at y=500,x=0 with PAGE_FRAMES=0 -> out_data0..7=0x00, out_latch high exactly 4 cycles starting 2 cycles after event, out_page=0.
- Req0 writes slot3=0xA5 and req1 writes slot3=0x5A simultaneously (pointer=0) -> ack0 on cycle+1, ack1 on cycle+2; next frame out_data3=0x5A.
- All 4 requesters held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each out_ack 1 cycle wide, no requester starved.
- PAGE_FRAMES=2, slot0=0x11, slot8=0x88 -> frames 1-2 show out_data0=0x11, page 0; frames 3-4 show 0x88, page 1; frame 5 shows 0x11 again.
- in_freeze=1 for 3 frame events while slot0 changes 0x11->0x22 -> no out_latch pulses, out_data0 stays 0x11, frame counter unchanged; after release, next event shows 0x22.
- Assert in_rst_n=0 during cycle 2 of out_latch -> out_latch and out_data* go 0 asynchronously; after release, no spurious pulse until the next frame event.
